dmem_arbiter: RTL

- Two-requester arbiter and sequencer in front of the single-port data RAM wrapper.
- Requester 0 is the core load/store unit; requester 1 is the loader/DMA port used for data preload and test injection.
- Arbitration is round-robin. Each granted transaction's owner ID goes into an in-order response FIFO, and every memory response is routed back to the requester that issued it.
- Sits between the core and the data RAM inside the core+memory top level.

---
 rtl/dmem_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for two requesters sharing one data RAM port.
// An in-order ID FIFO routes each RAM response back to the requester that issued it.
module dmem_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                req_i,
  input  logic [2*ADDR_WIDTH-1:0]   addr_i,
  input  logic [1:0]                we_i,
  input  logic [2*DATA_WIDTH/8-1:0] be_i,
  input  logic [2*DATA_WIDTH-1:0]   wdata_i,
  output logic [1:0]                gnt_o,
  output logic [1:0]                rvalid_o,
  output logic [DATA_WIDTH-1:0]     rdata_o,
  output logic                      mem_req_o,
  output logic [ADDR_WIDTH-1:0]     mem_addr_o,
  output logic                      mem_we_o,
  output logic [DATA_WIDTH/8-1:0]   mem_be_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  input  logic                      mem_gnt_i,
  input  logic                      mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic             rr_last_q, rr_last_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             id_q [MAX_OUTSTANDING];

  logic sel;
  logic fifo_empty;
  logic fifo_full;
  logic accept;
  logic pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_OUTSTANDING - 1)) return '0;
    return p + 1'b1;
  endfunction

  // A pending pop frees the slot in the same cycle, so a full FIFO can still accept.
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING)) & ~mem_rvalid_i;
    pop        = mem_rvalid_i & ~fifo_empty & ~rst;
    case (req_i)
      2'b01:   sel = 1'b0;
      2'b10:   sel = 1'b1;
      2'b11:   sel = ~rr_last_q;
      default: sel = 1'b0;
    endcase
  end

  assign mem_req_o   = (|req_i) & ~fifo_full & ~rst;
  assign accept      = mem_req_o & mem_gnt_i;
  assign gnt_o       = accept ? (sel ? 2'b10 : 2'b01) : 2'b00;

  assign mem_addr_o  = sel ? addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : addr_i[ADDR_WIDTH-1:0];
  assign mem_we_o    = sel ? we_i[1] : we_i[0];
  assign mem_be_o    = sel ? be_i[2*BE_W-1:BE_W] : be_i[BE_W-1:0];
  assign mem_wdata_o = sel ? wdata_i[2*DATA_WIDTH-1:DATA_WIDTH] : wdata_i[DATA_WIDTH-1:0];

  assign rvalid_o    = pop ? (id_q[rd_ptr_q] ? 2'b10 : 2'b01) : 2'b00;
  assign rdata_o     = mem_rdata_i;

  // Priority rotates only on an accepted transfer; a stall keeps the current pick.
  always_comb begin
    rr_last_d = rr_last_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (accept) begin
      rr_last_d = sel;
      wr_ptr_d  = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_q <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      rr_last_q <= rr_last_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) id_q[wr_ptr_q] <= sel;
  end
endmodule
